// File: rtl/ddr_port_arbiter_if.sv
// Requester, memory and status signals of the DDR port arbiter. The arbiter uses the slave modport.
// The SoC side, with the requesters and the memory model, uses the master modport.
interface ddr_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64
);
  localparam int MASK_W = DATA_W / 8;

  logic              ifu_req_vld;
  logic              ifu_req_rdy;
  logic [ADDR_W-1:0] ifu_req_addr;

  logic              lsu_req_vld;
  logic              lsu_req_rdy;
  logic [ADDR_W-1:0] lsu_req_addr;
  logic              lsu_req_we;
  logic [DATA_W-1:0] lsu_req_wdata;
  logic [MASK_W-1:0] lsu_req_wmask;

  logic              dbg_req_vld;
  logic              dbg_req_rdy;
  logic [ADDR_W-1:0] dbg_req_addr;
  logic              dbg_req_we;
  logic [DATA_W-1:0] dbg_req_wdata;
  logic [MASK_W-1:0] dbg_req_wmask;

  logic              ifu_rsp_vld;
  logic              lsu_rsp_vld;
  logic              dbg_rsp_vld;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_err;

  logic              mem_req_vld;
  logic              mem_req_rdy;
  logic [ADDR_W-1:0] mem_req_addr;
  logic              mem_req_we;
  logic [DATA_W-1:0] mem_req_wdata;
  logic [MASK_W-1:0] mem_req_wmask;
  logic              mem_rsp_vld;
  logic [DATA_W-1:0] mem_rsp_data;

  logic              busy;
  logic [1:0]        grant_id;

  modport slave (
    input  ifu_req_vld, ifu_req_addr,
    input  lsu_req_vld, lsu_req_addr, lsu_req_we, lsu_req_wdata, lsu_req_wmask,
    input  dbg_req_vld, dbg_req_addr, dbg_req_we, dbg_req_wdata, dbg_req_wmask,
    input  mem_req_rdy, mem_rsp_vld, mem_rsp_data,
    output ifu_req_rdy, lsu_req_rdy, dbg_req_rdy,
    output ifu_rsp_vld, lsu_rsp_vld, dbg_rsp_vld, rsp_data, rsp_err,
    output mem_req_vld, mem_req_addr, mem_req_we, mem_req_wdata, mem_req_wmask,
    output busy, grant_id
  );

  modport master (
    output ifu_req_vld, ifu_req_addr,
    output lsu_req_vld, lsu_req_addr, lsu_req_we, lsu_req_wdata, lsu_req_wmask,
    output dbg_req_vld, dbg_req_addr, dbg_req_we, dbg_req_wdata, dbg_req_wmask,
    output mem_req_rdy, mem_rsp_vld, mem_rsp_data,
    input  ifu_req_rdy, lsu_req_rdy, dbg_req_rdy,
    input  ifu_rsp_vld, lsu_rsp_vld, dbg_rsp_vld, rsp_data, rsp_err,
    input  mem_req_vld, mem_req_addr, mem_req_we, mem_req_wdata, mem_req_wmask,
    input  busy, grant_id
  );
endinterface

// File: rtl/ddr_port_arbiter.sv
// Shares one memory port between IFU, LSU and debug. Debug always wins; IFU and LSU alternate on a tie.
// One transaction in flight, at least 4 cycles; requesters see rdy=0 until IDLE, responses are never stalled.
module ddr_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 64,
  parameter int TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              rst,
  ddr_port_arbiter_if.slave bus
);
  localparam int MASK_W = DATA_W / 8;
  localparam int CNT_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  localparam logic [1:0] GNT_NONE = 2'd0;
  localparam logic [1:0] GNT_IFU  = 2'd1;
  localparam logic [1:0] GNT_LSU  = 2'd2;
  localparam logic [1:0] GNT_DBG  = 2'd3;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              we;
    logic [DATA_W-1:0] wdata;
    logic [MASK_W-1:0] wmask;
  } req_t;

  state_t            state;
  req_t              req_q;
  req_t              req_win;
  logic              rr_last_lsu;
  logic [CNT_W-1:0]  cnt;
  logic [1:0]        gnt;
  logic              mem_vld;
  logic              busy_q;
  logic              ifu_rsp;
  logic              lsu_rsp;
  logic              dbg_rsp;
  logic [DATA_W-1:0] rdata;
  logic              err;
  logic              idle_ok;
  logic              sel_ifu;
  logic              sel_lsu;
  logic              sel_dbg;

  // rr_last_lsu=1 means LSU was served last, so IFU wins the next tie
  always_comb begin
    idle_ok = rst && (state == IDLE);
    sel_dbg = idle_ok && bus.dbg_req_vld;
    sel_ifu = idle_ok && !bus.dbg_req_vld && bus.ifu_req_vld && (!bus.lsu_req_vld || rr_last_lsu);
    sel_lsu = idle_ok && !bus.dbg_req_vld && bus.lsu_req_vld && (!bus.ifu_req_vld || !rr_last_lsu);
    req_win = '0;
    if (sel_dbg) begin
      req_win.addr  = bus.dbg_req_addr;
      req_win.we    = bus.dbg_req_we;
      req_win.wdata = bus.dbg_req_wdata;
      req_win.wmask = bus.dbg_req_wmask;
    end else if (sel_lsu) begin
      req_win.addr  = bus.lsu_req_addr;
      req_win.we    = bus.lsu_req_we;
      req_win.wdata = bus.lsu_req_wdata;
      req_win.wmask = bus.lsu_req_wmask;
    end else if (sel_ifu) begin
      req_win.addr  = bus.ifu_req_addr;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      req_q       <= '0;
      rr_last_lsu <= 1'b1;
      cnt         <= '0;
      gnt         <= GNT_NONE;
      mem_vld     <= 1'b0;
      busy_q      <= 1'b0;
      ifu_rsp     <= 1'b0;
      lsu_rsp     <= 1'b0;
      dbg_rsp     <= 1'b0;
      rdata       <= '0;
      err         <= 1'b0;
    end else begin
      ifu_rsp <= 1'b0;
      lsu_rsp <= 1'b0;
      dbg_rsp <= 1'b0;
      unique case (state)
        IDLE: begin
          if (sel_dbg || sel_ifu || sel_lsu) begin
            req_q   <= req_win;
            gnt     <= sel_dbg ? GNT_DBG : (sel_lsu ? GNT_LSU : GNT_IFU);
            mem_vld <= 1'b1;
            busy_q  <= 1'b1;
            state   <= ISSUE;
            if (!sel_dbg) rr_last_lsu <= sel_lsu;
          end
        end
        ISSUE: begin
          if (bus.mem_req_rdy) begin
            mem_vld <= 1'b0;
            cnt     <= '0;
            state   <= WAIT;
          end
        end
        WAIT: begin
          if (bus.mem_rsp_vld || ((TIMEOUT != 0) && (cnt == CNT_LAST))) begin
            ifu_rsp <= (gnt == GNT_IFU);
            lsu_rsp <= (gnt == GNT_LSU);
            dbg_rsp <= (gnt == GNT_DBG);
            rdata   <= bus.mem_rsp_vld ? bus.mem_rsp_data : '0;
            err     <= !bus.mem_rsp_vld;
            state   <= RESP;
          end else if (cnt != '1) begin
            cnt <= cnt + 1'b1;
          end
        end
        RESP: begin
          gnt    <= GNT_NONE;
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.ifu_req_rdy   = sel_ifu;
  assign bus.lsu_req_rdy   = sel_lsu;
  assign bus.dbg_req_rdy   = sel_dbg;
  assign bus.ifu_rsp_vld   = ifu_rsp;
  assign bus.lsu_rsp_vld   = lsu_rsp;
  assign bus.dbg_rsp_vld   = dbg_rsp;
  assign bus.rsp_data      = rdata;
  assign bus.rsp_err       = err;
  assign bus.mem_req_vld   = mem_vld;
  assign bus.mem_req_addr  = req_q.addr;
  assign bus.mem_req_we    = req_q.we;
  assign bus.mem_req_wdata = req_q.wdata;
  assign bus.mem_req_wmask = req_q.wmask;
  assign bus.busy          = busy_q;
  assign bus.grant_id      = gnt;
endmodule

// File: doc/ddr_port_arbiter.md
Name: ddr_port_arbiter

Overview:
- Shares the single simulated-DDR memory port (ddr_inst) between three requesters: instruction fetch (IFU), load/store unit (LSU) and the debug-module system-bus access path (JTAG SBA writes to 0x8000_0000).
- Sits in riscv_soc between riscv_core_inst / debug module and ddr_inst.
- Single outstanding transaction. Debug has fixed top priority; IFU/LSU use round-robin.
- A response-timeout watchdog keeps a hung memory from deadlocking the core.

Parameters:
- ADDR_W, 32, request address width.
- DATA_W, 64, data width; the write mask is DATA_W/8 bits.
- TIMEOUT, 1024, WAIT-state cycle limit; 0 disables the watchdog.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-low
- ifu_req_vld  in  1  IFU read request
- ifu_req_rdy  out  1  IFU request accepted
- ifu_req_addr  in  ADDR_W  IFU address
- lsu_req_vld / dbg_req_vld  in  1  request valid
- lsu_req_rdy / dbg_req_rdy  out  1  request accepted
- lsu_req_addr / dbg_req_addr  in  ADDR_W  address
- lsu_req_we / dbg_req_we  in  1  1 = write
- lsu_req_wdata / dbg_req_wdata  in  DATA_W  write data
- lsu_req_wmask / dbg_req_wmask  in  DATA_W/8  byte enables
- ifu_rsp_vld / lsu_rsp_vld / dbg_rsp_vld  out  1  one-cycle response strobe to the owner
- rsp_data  out  DATA_W  shared read data
- rsp_err  out  1  shared error flag (timeout)
- mem_req_vld  out  1  memory request valid
- mem_req_rdy  in  1  memory request accepted
- mem_req_addr  out  ADDR_W  memory address
- mem_req_we  out  1  memory write enable
- mem_req_wdata  out  DATA_W  memory write data
- mem_req_wmask  out  DATA_W/8  memory byte enables
- mem_rsp_vld  in  1  memory response valid
- mem_rsp_data  in  DATA_W  memory read data
- busy  out  1  state != IDLE
- grant_id  out  2  current owner: 0 none, 1 IFU, 2 LSU, 3 DBG

Behaviour:
- Reset (rst==0 at a clk edge):
  - state=IDLE, all outputs 0, rr_last=LSU (so IFU wins the first tie), watchdog counter=0.
  - Reset mid-transaction aborts it. No response is sent, and a later mem_rsp_vld is ignored.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Any *_req_vld selects a winner: DBG if dbg_req_vld; else if only one of IFU/LSU is valid, that one; else the one != rr_last.
  - The winner's *_req_rdy is driven combinationally high in the same cycle (the only cycle any req_rdy may be 1).
  - On that edge: latch addr/we/wdata/wmask and grant_id; update rr_last only on an IFU or LSU grant; go to ISSUE.
  - IFU requests are always reads: we=0, wmask=0.
- ISSUE:
  - mem_req_vld=1 with the latched fields held stable.
  - On mem_req_rdy: go to WAIT, clear the counter.
- WAIT:
  - On mem_rsp_vld: register rsp_data=mem_rsp_data and rsp_err=0; go to RESP.
  - Otherwise the counter increments. If TIMEOUT!=0 and counter==TIMEOUT-1: rsp_data=0, rsp_err=1, go to RESP.
- RESP:
  - The owner's *_rsp_vld=1 for exactly one cycle; rsp_data/rsp_err are valid only in this cycle. There is no response backpressure.
  - Next state IDLE; grant_id is cleared on entering IDLE.
- Write responses are also strobed (acknowledge); rsp_data is don't-care for writes.
- mem_rsp_vld outside WAIT is dropped, with no state change.
- Latency:
  - Request accepted at edge T puts mem_req_vld high in cycle T+1.
  - mem_rsp_vld in cycle X puts *_rsp_vld high in cycle X+1.
  - Minimum turnaround is 4 cycles per transaction (zero-wait memory).
- Requests arriving in ISSUE/WAIT/RESP are held by the requester (rdy=0). A requester must keep vld and payload stable until rdy.
- Counter width: $clog2(TIMEOUT+1), saturating; no wrap.

Test Plan:
- IFU read, addr 0x8000_0000; memory rdy immediate, rsp 2 cycles later with 0x0000_0013_0000_0093:
  - ifu_req_rdy in cycle 0, mem_req_vld in cycle 1.
  - ifu_rsp_vld one cycle after mem_rsp_vld, rsp_data=0x0000_0013_0000_0093, rsp_err=0.
- IFU and LSU both valid continuously, 4 transactions:
  - grants IFU, LSU, IFU, LSU; grant_id 1,2,1,2.
- DBG write (addr 0x8000_0000, wdata 0xf2580000, wmask 0xFF) asserted together with IFU+LSU:
  - DBG granted first, mem_req_we=1, dbg_rsp_vld=1.
  - The IFU/LSU rotation then resumes with IFU.
- TIMEOUT=8, memory never responds:
  - exactly 8 WAIT cycles, then lsu_rsp_vld=1 with rsp_err=1, rsp_data=0, busy drops.
  - A late mem_rsp_vld is ignored.
- mem_req_rdy held low 5 cycles:
  - mem_req_vld/addr/wdata stable all 5 cycles.
  - New requests see rdy=0 throughout.
- rst=0 asserted in WAIT:
  - next cycle state IDLE, busy=0, grant_id=0.
  - The following mem_rsp_vld produces no *_rsp_vld.
  - After release, an IFU+LSU tie grants IFU.
